// File: rtl/irda_link_sequencer.sv
// Sequences IrDA mode changes onto the TX/RX engines: drain the active datapath,
// wait a dark turnaround, then commit the requested configuration.
module irda_link_sequencer #(
    parameter int TURNAROUND_CYCLES = 16,
    parameter int DRAIN_TIMEOUT     = 4096,
    parameter int CNT_W             = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_fast_mode,
    input  logic       req_mir_mode,
    input  logic       req_mir_half,
    input  logic       req_fir_mode,
    input  logic       req_tx_select,
    input  logic       req_loopback,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       cfg_fast_mode,
    output logic       cfg_mir_mode,
    output logic       cfg_mir_half,
    output logic       cfg_fir_mode,
    output logic       cfg_tx_select,
    output logic       cfg_loopback,
    output logic       tx_enable,
    output logic       rx_enable,
    output logic       quiesce_req,
    output logic       switching,
    output logic       switch_done,
    output logic       drain_timeout,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_APPLY  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       cfg_q, cfg_d;
    logic             switch_done_q, switch_done_d;
    logic             drain_timeout_q, drain_timeout_d;
    logic [5:0]       req_w;
    logic             datapath_on;

    assign req_w = {req_fast_mode, req_mir_mode, req_mir_half,
                    req_fir_mode, req_tx_select, req_loopback};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q         <= ST_SETTLE;
            cnt_q           <= '0;
            cfg_q           <= '0;
            switch_done_q   <= 1'b0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cfg_q           <= cfg_d;
            switch_done_q   <= switch_done_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cfg_d           = cfg_q;
        switch_done_d   = 1'b0;
        drain_timeout_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (req_w != cfg_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Cancel beats idle, idle beats timeout.
                if (req_w == cfg_q) begin
                    state_d = ST_RUN;
                end else if (!tx_busy && !rx_busy) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d         = ST_SETTLE;
                    cnt_d           = '0;
                    drain_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TURN_LAST) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cfg_d         = req_w;
                state_d       = ST_RUN;
                switch_done_d = 1'b1;
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Enables keep their RUN values through DRAIN so an in-flight frame can finish.
    assign datapath_on = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    assign {cfg_fast_mode, cfg_mir_mode, cfg_mir_half,
            cfg_fir_mode, cfg_tx_select, cfg_loopback} = cfg_q;

    assign tx_enable     = datapath_on & cfg_q[1];
    assign rx_enable     = datapath_on & (~cfg_q[1] | cfg_q[0]);
    assign quiesce_req   = (state_q == ST_DRAIN);
    assign switching     = (state_q != ST_RUN);
    assign switch_done   = switch_done_q;
    assign drain_timeout = drain_timeout_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_irda_link_sequencer.sv
// Directed bench for irda_link_sequencer: a step table for the main sequences plus
// hand-written reset, recovery and drain-timeout sequences.
module tb_irda_link_sequencer;

    localparam int T_CYC  = 16;
    localparam int D_TO   = 8;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_APPLY  = 2'd3;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic       txb, rxb;
    logic       cfg_fast_mode, cfg_mir_mode, cfg_mir_half, cfg_fir_mode;
    logic       cfg_tx_select, cfg_loopback;
    logic       tx_enable, rx_enable, quiesce_req, switching, switch_done, drain_timeout;
    logic [1:0] dbg_state;
    logic [5:0] cfg_w;
    logic [11:0] out_w;

    int n_checks = 0;
    int n_pass   = 0;

    irda_link_sequencer #(
        .TURNAROUND_CYCLES(T_CYC),
        .DRAIN_TIMEOUT    (D_TO),
        .CNT_W            (16)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .req_fast_mode (req[5]),
        .req_mir_mode  (req[4]),
        .req_mir_half  (req[3]),
        .req_fir_mode  (req[2]),
        .req_tx_select (req[1]),
        .req_loopback  (req[0]),
        .tx_busy       (txb),
        .rx_busy       (rxb),
        .cfg_fast_mode (cfg_fast_mode),
        .cfg_mir_mode  (cfg_mir_mode),
        .cfg_mir_half  (cfg_mir_half),
        .cfg_fir_mode  (cfg_fir_mode),
        .cfg_tx_select (cfg_tx_select),
        .cfg_loopback  (cfg_loopback),
        .tx_enable     (tx_enable),
        .rx_enable     (rx_enable),
        .quiesce_req   (quiesce_req),
        .switching     (switching),
        .switch_done   (switch_done),
        .drain_timeout (drain_timeout),
        .dbg_state_o   (dbg_state)
    );

    assign cfg_w = {cfg_fast_mode, cfg_mir_mode, cfg_mir_half,
                    cfg_fir_mode, cfg_tx_select, cfg_loopback};
    // {cfg[5:0], tx_en, rx_en, quiesce, switching, switch_done, drain_timeout}
    assign out_w = {cfg_w, tx_enable, rx_enable, quiesce_req, switching, switch_done, drain_timeout};

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [5:0]  req;
        logic        txb;
        logic        rxb;
        int          edges;
        logic [1:0]  st;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic [5:0] r, input logic tb_, input logic rb_, input int e,
                       input logic [1:0] st, input logic [5:0] cfg, input logic tx, input logic rx,
                       input logic q, input logic sw, input logic sd, input logic dt);
        vec_t v;
        v.req = r; v.txb = tb_; v.rxb = rb_; v.edges = e; v.st = st;
        v.exp = {cfg, tx, rx, q, sw, sd, dt};
        vecs.push_back(v);
    endtask

    // Called at the negedge where reset was released; expects a cfg==0 commit.
    task automatic recover(input string tag);
        int dark;
        dark = 0;
        while (!(tx_enable || rx_enable) && dark < 100) begin
            dark++;
            @(negedge clk);
        end
        check({tag, "_dark_cycles"}, dark, T_CYC + 1);
        check({tag, "_run_out"}, out_w, {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        check({tag, "_run_state"}, dbg_state, S_RUN);
        @(negedge clk);
        check({tag, "_done_clear"}, switch_done, 1'b0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; req = '0; txb = 1'b0; rxb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", out_w, {6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check("reset_state", dbg_state, S_SETTLE);
        rst = 1'b0;
        recover("s1");

        // Receive -> transmit with rx_busy held through the first DRAIN cycles
        add(6'b000010, 0, 1, 1,  S_DRAIN,  6'b000000, 0, 1, 1, 1, 0, 0);
        add(6'b000010, 0, 1, 4,  S_DRAIN,  6'b000000, 0, 1, 1, 1, 0, 0);
        add(6'b000010, 0, 0, 1,  S_SETTLE, 6'b000000, 0, 0, 0, 1, 0, 0);
        add(6'b000010, 0, 0, 15, S_SETTLE, 6'b000000, 0, 0, 0, 1, 0, 0);
        add(6'b000010, 0, 0, 1,  S_APPLY,  6'b000000, 0, 0, 0, 1, 0, 0);
        add(6'b000010, 0, 0, 1,  S_RUN,    6'b000010, 1, 0, 0, 0, 1, 0);
        add(6'b000010, 0, 0, 1,  S_RUN,    6'b000010, 1, 0, 0, 0, 0, 0);
        // Cancel: request restored while still busy
        add(6'b000000, 1, 0, 1,  S_DRAIN,  6'b000010, 1, 0, 1, 1, 0, 0);
        add(6'b000010, 1, 0, 1,  S_RUN,    6'b000010, 1, 0, 0, 0, 0, 0);
        add(6'b000010, 1, 0, 1,  S_RUN,    6'b000010, 1, 0, 0, 0, 0, 0);
        // FIR requested, switched to MIR during SETTLE
        add(6'b100110, 0, 0, 1,  S_DRAIN,  6'b000010, 1, 0, 1, 1, 0, 0);
        add(6'b100110, 0, 0, 1,  S_SETTLE, 6'b000010, 0, 0, 0, 1, 0, 0);
        add(6'b110010, 0, 0, 5,  S_SETTLE, 6'b000010, 0, 0, 0, 1, 0, 0);
        add(6'b110010, 0, 0, 10, S_SETTLE, 6'b000010, 0, 0, 0, 1, 0, 0);
        add(6'b110010, 0, 0, 1,  S_APPLY,  6'b000010, 0, 0, 0, 1, 0, 0);
        add(6'b110010, 0, 0, 1,  S_RUN,    6'b110010, 1, 0, 0, 0, 1, 0);
        add(6'b110010, 0, 0, 1,  S_RUN,    6'b110010, 1, 0, 0, 0, 0, 0);
        // Request changed during APPLY: the value at the exit edge is committed
        add(6'b000011, 0, 0, 1,  S_DRAIN,  6'b110010, 1, 0, 1, 1, 0, 0);
        add(6'b000011, 0, 0, 17, S_APPLY,  6'b110010, 0, 0, 0, 1, 0, 0);
        add(6'b000001, 0, 0, 1,  S_RUN,    6'b000001, 0, 1, 0, 0, 1, 0);
        add(6'b000001, 0, 0, 1,  S_RUN,    6'b000001, 0, 1, 0, 0, 0, 0);
        // Transmit with loopback keeps both datapaths enabled
        add(6'b000011, 0, 0, 1,  S_DRAIN,  6'b000001, 0, 1, 1, 1, 0, 0);
        add(6'b000011, 0, 0, 17, S_APPLY,  6'b000001, 0, 0, 0, 1, 0, 0);
        add(6'b000011, 0, 0, 1,  S_RUN,    6'b000011, 1, 1, 0, 0, 1, 0);
        add(6'b000011, 0, 0, 1,  S_RUN,    6'b000011, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req; txb = vecs[i].txb; rxb = vecs[i].rxb;
            repeat (vecs[i].edges) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_out", i), out_w, vecs[i].exp);
            check($sformatf("vec%0d_state", i), dbg_state, vecs[i].st);
        end

        // tx_busy stuck high: DRAIN bounded by the timeout
        req = 6'b000000; txb = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (quiesce_req && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("to_drain_cycles", cnt, D_TO);
        check("to_pulse", drain_timeout, 1'b1);
        check("to_state", dbg_state, S_SETTLE);
        @(negedge clk);
        check("to_pulse_clear", drain_timeout, 1'b0);
        repeat (16) @(negedge clk);
        check("to_commit_out", out_w, {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        txb = 1'b0;

        // Asynchronous reset mid-SETTLE
        req = 6'b000010;
        repeat (5) @(negedge clk);
        check("pre_rst_settle", dbg_state, S_SETTLE);
        #2 rst = 1'b1;
        #1 check("rst_settle_out", out_w, {6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        recover("s6a");

        // Asynchronous reset mid-DRAIN
        req = 6'b000010; rxb = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_drain", quiesce_req, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_drain_out", out_w, {6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        req = '0; rxb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        recover("s6b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
